bus_responder: RTL and testbench

Memory-side responder for the core's 64-bit data bus: it services the core's `address`/`datao`/`rw` requests with a word-addressed program/data RAM plus a small memory-mapped I/O window, returning read data on the core's `data` input. After reset it also acts as the program loader. It holds the core in reset, accepts program words over a valid/ready stream, then releases the core and switches to bus-service mode. It sits at top level between the core and the outside world.

---
 rtl/bus_responder.sv | 149 ++++++++++++++
 tb/tb_bus_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_responder.sv
// Memory-side responder for the core's 64-bit data bus.
// Loads the program into RAM, then serves RAM and MMIO reads and writes.
module bus_responder #(
  parameter int unsigned ADDR_BITS = 8,
  parameter logic [63:0] MMIO_BASE = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] address,
  input  logic [63:0] wdata,
  input  logic        rw,
  output logic [63:0] rdata,
  input  logic        load_valid,
  input  logic [63:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_reset,
  output logic        out_valid,
  output logic [63:0] out_data,
  input  logic [63:0] in_data,
  output logic        fault
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [63:0] RAM_TOP = 64'(1) << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_MAX = '1;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [63:0] rdata_q, rdata_d;
  logic [63:0] out_q, out_d;
  logic [63:0] cyc_q, cyc_d;
  logic        ov_q, ov_d;
  logic        fault_q, fault_d;

  logic [63:0] mem [DEPTH];
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [63:0]          mem_wd;
  logic [63:0]          mem_rd;

  logic [ADDR_BITS-1:0] idx;
  logic hit_ram, hit_out, hit_cyc, hit_in, hit_none;

  assign idx    = address[ADDR_BITS-1:0];
  assign mem_rd = mem[idx];

  // Decode the core's word address into RAM, the three MMIO slots, or a hole.
  always_comb begin
    hit_ram  = (address < RAM_TOP);
    hit_out  = (address == MMIO_BASE);
    hit_cyc  = (address == MMIO_BASE + 64'd1);
    hit_in   = (address == MMIO_BASE + 64'd2);
    hit_none = !(hit_ram || hit_out || hit_cyc || hit_in);
  end

  // Next-state logic: loader stream in LOAD, bus service in RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    out_d   = out_q;
    cyc_d   = cyc_q;
    ov_d    = 1'b0;
    fault_d = fault_q;
    mem_we  = 1'b0;
    mem_wa  = ptr_q;
    mem_wd  = load_data;
    unique case (state_q)
      S_LOAD: begin
        rdata_d = '0;
        if (load_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + ADDR_BITS'(1);
          if (load_last || ptr_q == PTR_MAX) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 64'd1;
        if (rw) begin
          unique case (1'b1)
            hit_ram: rdata_d = mem_rd;
            hit_out: rdata_d = out_q;
            hit_cyc: rdata_d = cyc_q;
            hit_in:  rdata_d = in_data;
            default: rdata_d = '0;
          endcase
        end else begin
          if (hit_ram) begin
            mem_we = 1'b1;
            mem_wa = idx;
            mem_wd = wdata;
          end
          if (hit_out) begin
            out_d = wdata;
            ov_d  = 1'b1;
          end
        end
        if (hit_none) begin
          fault_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control and status registers; reset wins over any activity on the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      rdata_q <= '0;
      out_q   <= '0;
      cyc_q   <= '0;
      ov_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      cyc_q   <= cyc_d;
      ov_q    <= ov_d;
      fault_q <= fault_d;
    end
  end

  // RAM write port; contents survive reset but a write on a reset edge is dropped.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign rdata      = rdata_q;
  assign load_ready = (state_q == S_LOAD);
  assign core_reset = (state_q == S_LOAD);
  assign out_valid  = ov_q;
  assign out_data   = out_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_bus_responder.sv
// Randomized bench for bus_responder against a transaction-level model.
// Also checks a 4-word instance for the RAM-full load boundary.
module tb_bus_responder;

  localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FF00;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] address, wdata, rdata, load_data, out_data, in_data;
  logic        rw, load_valid, load_last, load_ready;
  logic        core_reset, out_valid, fault;

  logic        s_reset, s_rw, s_load_valid, s_load_last, s_load_ready;
  logic        s_core_reset, s_out_valid, s_fault;
  logic [63:0] s_address, s_load_data, s_rdata, s_out_data;
  logic [63:0] s_zero = '0;

  int n_chk = 0;
  int n_pass = 0;

  logic [63:0] m_mem [256];
  bit          m_run;
  int          m_ptr;
  logic [63:0] m_rd, m_out, m_cyc;
  bit          m_ov, m_fault;

  always #5 clock = ~clock;

  bus_responder dut (
    .clock(clock), .reset(reset), .address(address), .wdata(wdata),
    .rw(rw), .rdata(rdata), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .core_reset(core_reset),
    .out_valid(out_valid), .out_data(out_data), .in_data(in_data),
    .fault(fault)
  );

  bus_responder #(.ADDR_BITS(2)) dut_s (
    .clock(clock), .reset(s_reset), .address(s_address),
    .wdata(s_zero), .rw(s_rw), .rdata(s_rdata),
    .load_valid(s_load_valid), .load_data(s_load_data),
    .load_last(s_load_last), .load_ready(s_load_ready),
    .core_reset(s_core_reset), .out_valid(s_out_valid),
    .out_data(s_out_data), .in_data(s_zero), .fault(s_fault)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One rising edge as the spec describes it, in terms of bus transactions.
  task automatic model_edge();
    m_ov = 1'b0;
    if (reset) begin
      m_run = 0; m_ptr = 0; m_rd = '0;
      m_out = '0; m_fault = 0; m_cyc = '0;
    end else if (!m_run) begin
      m_rd = '0;
      if (load_valid) begin
        m_mem[m_ptr] = load_data;
        if (load_last || m_ptr == 255) m_run = 1;
        m_ptr = (m_ptr + 1) % 256;
      end
    end else begin
      if (address < 64'd256) begin
        if (rw) m_rd = m_mem[address[7:0]];
        else m_mem[address[7:0]] = wdata;
      end else if (address == BASE) begin
        if (rw) m_rd = m_out;
        else begin m_out = wdata; m_ov = 1'b1; end
      end else if (address == BASE + 64'd1) begin
        if (rw) m_rd = m_cyc;
      end else if (address == BASE + 64'd2) begin
        if (rw) m_rd = in_data;
      end else begin
        if (rw) m_rd = '0;
        m_fault = 1;
      end
      m_cyc = m_cyc + 64'd1;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("rdata", rdata, m_rd);
    check("core_reset", 64'(core_reset), 64'(!m_run));
    check("load_ready", 64'(load_ready), 64'(!m_run));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("out_data", out_data, m_out);
    check("fault", 64'(fault), 64'(m_fault));
  endtask

  logic [63:0] w [5];
  logic [63:0] w1;
  int sel;

  initial begin
    reset = 1; address = '0; wdata = '0; rw = 1;
    load_valid = 0; load_data = '0; load_last = 0; in_data = '0;
    s_reset = 1; s_rw = 1; s_address = '0;
    s_load_valid = 0; s_load_data = '0; s_load_last = 0;
    step();
    step();

    // 4-word instance: five words streamed, no last marker.
    s_reset = 0;
    s_load_valid = 1;
    for (int i = 0; i < 5; i++) begin
      w[i] = rnd64();
      s_load_data = w[i];
      step();
      check("s_load_ready", 64'(s_load_ready), 64'(i < 3));
    end
    s_load_valid = 0;
    for (int j = 0; j < 4; j++) begin
      s_address = 64'(j);
      step();
      check("s_rdata", s_rdata, w[j]);
    end
    check("s_core_reset", 64'(s_core_reset), 64'd0);
    s_reset = 1;

    // Fill all 256 words; RAM-full ends the load.
    reset = 0;
    load_valid = 1;
    for (int i = 0; i < 256; i++) begin
      load_data = rnd64();
      step();
    end
    address = 64'd1; rw = 1;
    step();

    in_data = 64'hA5; address = BASE + 64'd2; rw = 1;
    step();
    check("in_read", rdata, 64'hA5);
    rw = 0; wdata = rnd64();
    step();

    address = BASE; wdata = 64'h1234;
    step();
    check("out_pulse", 64'(out_valid), 64'd1);
    check("out_val", out_data, 64'h1234);
    rw = 1; address = 64'd0;
    step();

    address = 64'd5; rw = 0; wdata = 64'hDEAD;
    step();
    rw = 1;
    step();
    check("dead_rd", rdata, 64'hDEAD);
    address = 64'd256;
    step();
    check("fault_set", 64'(fault), 64'd1);
    address = 64'd7;
    step();
    step();

    // One-cycle reset with a write that must be discarded.
    reset = 1; rw = 0; address = 64'd5; wdata = 64'hBEEF;
    step();
    check("rst_core", 64'(core_reset), 64'd1);
    reset = 0;

    // Three-word program with last marker; bus traffic ignored in LOAD.
    load_valid = 1;
    for (int i = 0; i < 3; i++) begin
      load_data = rnd64();
      if (i == 1) w1 = load_data;
      load_last = (i == 2);
      if (i == 2) begin address = 64'd1; rw = 1; end
      step();
    end
    load_last = 0;
    check("run_entered", 64'(core_reset), 64'd0);
    step();
    check("first_read", rdata, w1);
    address = 64'd5;
    for (int i = 0; i < 9; i++) step();
    check("dead_kept", rdata, 64'hDEAD);
    address = BASE + 64'd1;
    step();
    check("cycles10", rdata, 64'd10);

    // Random traffic with occasional resets and loader noise.
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_last = ($urandom_range(0, 7) == 0);
      load_data = rnd64();
      in_data = rnd64();
      wdata = rnd64();
      rw = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 19);
      if (sel == 14) address = BASE;
      else if (sel == 15) address = BASE + 64'd1;
      else if (sel == 16) address = BASE + 64'd2;
      else if (sel == 17) address = BASE + 64'd3;
      else if (sel == 18) address = 64'd256 + 64'($urandom_range(0, 999));
      else address = 64'($urandom_range(0, 255));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
